conv_pass_sequencer: RTL and testbench
======================================

Name: conv_pass_sequencer

Overview:
- FSM-based sequencer for the conv → accumulate → maxpool datapath. It replaces fixed cycle-count decoding with a start/busy/task_over handshake.
- Runs a runtime-configurable number of input-channel passes over one ROW_NUM×COL_NUM feature map.
- Per pass it gates the conv line buffer, asserts accumulate-valid once the window is filled, reads partial sums on passes after the first, and feeds maxpool on the final pass.
- Sits between the input-stream source and the conv/accu/maxpool units.

Parameters:
- COL_NUM, 128, feature-map width in pixels.
- ROW_NUM, 128, feature-map height in pixels.
- FILL_LAT, 2*COL_NUM, number of accepted pixels before the first valid conv window in a pass.
- PASS_MAX, 8, maximum number of passes; sets the cfg clamp value.
- CNT_W, 32, pixel counter width; must hold COL_NUM*ROW_NUM.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  1-cycle request to begin a task; ignored unless busy=0.
- abort  in  1  synchronous abort; returns the FSM to IDLE.
- cfg_pass_num  in  8  number of passes; latched at start.
- pixel_valid  in  1  input pixel accepted this cycle.
- busy  out  1  high from the cycle after start until task_over.
- pass_idx  out  8  current pass, 0-based.
- rst_n_conv  out  1  active-low clear for the conv line buffers.
- valid_in_conv  out  1  conv unit enable.
- valid_in_accu  out  1  conv result valid into the accumulator.
- valid_in_rd_en  out  1  partial-sum buffer read enable.
- valid_in_maxpool  out  1  final-pass result valid into maxpool.
- task_over  out  1  1-cycle done pulse.

Behaviour:
- All outputs are registered.
- Reset values: rst_n_conv=1; busy, valid_in_conv, valid_in_accu, valid_in_rd_en, valid_in_maxpool, task_over = 0; pass_idx=0; internal pix_cnt=0; state=IDLE.
- Define N = COL_NUM*ROW_NUM and P = latched pass count. cfg_pass_num=0 is treated as 1; values above PASS_MAX clamp to PASS_MAX.
- IDLE
  - Data-path outputs are 0 and pixel_valid is ignored.
  - start → latch P, pix_cnt=0, pass_idx=0, go to PASS.
  - busy and valid_in_conv are 1 from the next cycle.
- PASS
  - valid_in_conv=1.
  - Each cycle with pixel_valid=1 increments pix_cnt.
  - valid_in_accu(t+1) = pixel_valid(t) && pix_cnt(t) >= FILL_LAT. This gives exactly N-FILL_LAT pulses per pass.
  - valid_in_rd_en(t+1) = the same condition && pass_idx != 0.
  - valid_in_maxpool(t+1) = the same condition && pass_idx == P-1.
  - pixel_valid=0 holds the counter and drops all three valids on the next cycle.
  - Accepting pixel N-1 → go to GAP.
- GAP (1 cycle)
  - valid_in_conv=0, rst_n_conv=0, pix_cnt cleared.
  - pixel_valid is ignored; the upstream source must not present a pixel here.
  - If pass_idx == P-1 → go to DONE; else pass_idx+1 → go to PASS.
  - rst_n_conv returns to 1 on leaving GAP.
- DONE (1 cycle): task_over=1, then busy=0 → IDLE. pass_idx holds its last value until the next start.
- start while busy is ignored and does not re-latch cfg.
- abort in any non-IDLE state → next cycle state=IDLE with all data-path outputs at reset values. One cycle of rst_n_conv=0 is issued during abort to clear the line buffers. No task_over pulse is generated.
- abort and start in the same cycle: abort wins and the FSM stays in IDLE.
- Async reset mid-task forces reset values immediately.
- Counter wrap is impossible by construction: pix_cnt is cleared at N.

Optional Feature:
- Macro: SEQ_STALL_CNT_EN.
- Defined: adds output stall_cnt[31:0], which counts PASS cycles with pixel_valid=0.
  - Cleared on accepted start.
  - Saturates at 0xFFFFFFFF.
  - Holds its value after task_over and after abort.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan (COL_NUM=4, ROW_NUM=4, FILL_LAT=8, PASS_MAX=8):
- Single pass: cfg=1, start, pixel_valid held 1 → 8 accu pulses and 8 maxpool pulses, 0 rd_en pulses, one GAP cycle with rst_n_conv=0, task_over 18 cycles after start, busy falls on the following cycle.
- Three passes: cfg=3, continuous pixels → 24 accu pulses, 16 rd_en pulses (passes 1–2), 8 maxpool pulses (pass 2 only), pass_idx sequence 0,1,2, 3 rst_n_conv low pulses.
- Bubbles: cfg=1, pixel_valid toggles 1/0 → still exactly 8 accu pulses, each following an accepted pixel index ≥8; valids are 0 the cycle after each bubble; with SEQ_STALL_CNT_EN, stall_cnt=15.
- Config edges: cfg=0 → behaves as 1 pass; cfg=20 → 8 passes, final pass_idx=7.
- Abort: abort on the 5th pixel of pass 1 → next cycle IDLE, busy=0, no task_over, a later start runs cleanly from pass 0.
- Protocol: start while busy has no effect; abort+start in the same cycle from IDLE → remains IDLE; async rst_n low mid-PASS → all outputs at reset values immediately.

Source files
------------

// File: rtl/conv_pass_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pass_sequencer
//  Description : Start/busy/task_over sequencer for the conv -> accumulate ->
//                maxpool datapath. Runs a configurable number of
//                input-channel passes over one ROW_NUM x COL_NUM feature map,
//                gating the conv line buffer and steering the accumulate,
//                partial-sum read and maxpool valids per pass.
//                Optional macro SEQ_STALL_CNT_EN adds the stall_cnt output.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_pass_sequencer #(
    parameter int COL_NUM  = 128,
    parameter int ROW_NUM  = 128,
    parameter int FILL_LAT = 2 * COL_NUM,
    parameter int PASS_MAX = 8,
    parameter int CNT_W    = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] cfg_pass_num,
    input  logic       pixel_valid,
    output logic       busy,
    output logic [7:0] pass_idx,
    output logic       rst_n_conv,
    output logic       valid_in_conv,
    output logic       valid_in_accu,
    output logic       valid_in_rd_en,
    output logic       valid_in_maxpool,
    output logic       task_over
`ifdef SEQ_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(COL_NUM * ROW_NUM - 1);
    localparam logic [CNT_W-1:0] FILL_C   = CNT_W'(FILL_LAT);
    localparam logic [7:0]       PASS_LIM = 8'(PASS_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] pix_cnt;
    logic [7:0]       pass_num;
    logic [7:0]       cfg_clamped;
    logic             fill_ok;
    logic             last_pass;
    logic             start_ok;

    // Pass count clamp: zero means one pass, anything above the limit saturates.
    always_comb begin
        cfg_clamped = cfg_pass_num;
        if (cfg_pass_num == 8'd0) begin
            cfg_clamped = 8'd1;
        end else if (cfg_pass_num > PASS_LIM) begin
            cfg_clamped = PASS_LIM;
        end
    end

    assign fill_ok   = (pix_cnt >= FILL_C);
    assign last_pass = (pass_idx == (pass_num - 8'd1));
    assign start_ok  = (state == S_IDLE) && start && !abort;

    // Sequencer FSM; every output is registered and reflects the state entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            pix_cnt          <= '0;
            pass_num         <= 8'd1;
            pass_idx         <= 8'd0;
            busy             <= 1'b0;
            rst_n_conv       <= 1'b1;
            valid_in_conv    <= 1'b0;
            valid_in_accu    <= 1'b0;
            valid_in_rd_en   <= 1'b0;
            valid_in_maxpool <= 1'b0;
            task_over        <= 1'b0;
        end else begin
            task_over  <= 1'b0;
            rst_n_conv <= 1'b1;
            case (state)
                S_IDLE: begin
                    busy             <= 1'b0;
                    valid_in_conv    <= 1'b0;
                    valid_in_accu    <= 1'b0;
                    valid_in_rd_en   <= 1'b0;
                    valid_in_maxpool <= 1'b0;
                    if (start_ok) begin
                        pass_num      <= cfg_clamped;
                        pix_cnt       <= '0;
                        pass_idx      <= 8'd0;
                        busy          <= 1'b1;
                        valid_in_conv <= 1'b1;
                        state         <= S_PASS;
                    end
                end
                S_PASS: begin
                    // A valid follows each accepted pixel once the window is filled.
                    valid_in_accu    <= pixel_valid && fill_ok;
                    valid_in_rd_en   <= pixel_valid && fill_ok && (pass_idx != 8'd0);
                    valid_in_maxpool <= pixel_valid && fill_ok && last_pass;
                    if (pixel_valid) begin
                        if (pix_cnt == PIX_LAST) begin
                            pix_cnt       <= '0;
                            valid_in_conv <= 1'b0;
                            rst_n_conv    <= 1'b0;
                            state         <= S_GAP;
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    valid_in_accu    <= 1'b0;
                    valid_in_rd_en   <= 1'b0;
                    valid_in_maxpool <= 1'b0;
                    pix_cnt          <= '0;
                    if (last_pass) begin
                        task_over <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        pass_idx      <= pass_idx + 8'd1;
                        valid_in_conv <= 1'b1;
                        state         <= S_PASS;
                    end
                end
                S_DONE: begin
                    busy             <= 1'b0;
                    valid_in_accu    <= 1'b0;
                    valid_in_rd_en   <= 1'b0;
                    valid_in_maxpool <= 1'b0;
                    state            <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Abort overrides whatever the state above decided and pulses the
            // line-buffer clear once; pass_idx keeps its value like after DONE.
            if (abort && (state != S_IDLE)) begin
                state            <= S_IDLE;
                pix_cnt          <= '0;
                pass_idx         <= pass_idx;
                busy             <= 1'b0;
                rst_n_conv       <= 1'b0;
                valid_in_conv    <= 1'b0;
                valid_in_accu    <= 1'b0;
                valid_in_rd_en   <= 1'b0;
                valid_in_maxpool <= 1'b0;
                task_over        <= 1'b0;
            end
        end
    end

`ifdef SEQ_STALL_CNT_EN
    // Saturating count of PASS cycles without an input pixel; kept after the task.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
        end else if (start_ok) begin
            stall_cnt <= 32'd0;
        end else if ((state == S_PASS) && !pixel_valid && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_pass_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_pass_sequencer
//  Description : Self-checking bench for conv_pass_sequencer (4x4 map,
//                FILL_LAT=8, PASS_MAX=8). Directed vector table for protocol
//                corners plus multi-cycle runs checked against a cycle model
//                and hand-computed pulse totals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_pass_sequencer;

    localparam int COL  = 4;
    localparam int ROW  = 4;
    localparam int FILL = 8;
    localparam int PMAX = 8;
    localparam int NPIX = COL * ROW;

    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_PASS = 2'd1;
    localparam logic [1:0] M_GAP  = 2'd2;
    localparam logic [1:0] M_DONE = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] cfg_pass_num = 8'd0;
    logic       pixel_valid = 1'b0;
    logic       busy;
    logic [7:0] pass_idx;
    logic       rst_n_conv;
    logic       valid_in_conv;
    logic       valid_in_accu;
    logic       valid_in_rd_en;
    logic       valid_in_maxpool;
    logic       task_over;
`ifdef SEQ_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    conv_pass_sequencer #(
        .COL_NUM (COL),
        .ROW_NUM (ROW),
        .FILL_LAT(FILL),
        .PASS_MAX(PMAX),
        .CNT_W   (32)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .cfg_pass_num    (cfg_pass_num),
        .pixel_valid     (pixel_valid),
        .busy            (busy),
        .pass_idx        (pass_idx),
        .rst_n_conv      (rst_n_conv),
        .valid_in_conv   (valid_in_conv),
        .valid_in_accu   (valid_in_accu),
        .valid_in_rd_en  (valid_in_rd_en),
        .valid_in_maxpool(valid_in_maxpool),
        .task_over       (task_over)
`ifdef SEQ_STALL_CNT_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    logic [14:0] act_vec;
    assign act_vec = {busy, pass_idx, rst_n_conv, valid_in_conv, valid_in_accu,
                      valid_in_rd_en, valid_in_maxpool, task_over};

    int n_tests = 0;
    int n_fail  = 0;

    // Cycle model state
    logic [1:0] m_state = M_IDLE;
    int m_pass = 0;
    int m_pix  = 0;
    int m_p    = 1;
    bit m_clr, m_acc, m_rd, m_mp;

    // Pulse totals observed on the DUT during one run
    int cnt_acc, cnt_rd, cnt_mp, cnt_clr, cnt_to, max_pidx;

    typedef struct {
        logic        st;
        logic        ab;
        logic [7:0]  cfg;
        logic        pv;
        logic [14:0] exp;
    } vec_t;

    function automatic logic [14:0] pk(input bit b, input int pidx, input bit rc, input bit cv,
                                       input bit ac, input bit rd, input bit mp, input bit to);
        return {b, 8'(pidx), rc, cv, ac, rd, mp, to};
    endfunction

    function automatic int clamp_cfg(input int c);
        if (c == 0) return 1;
        if (c > PMAX) return PMAX;
        return c;
    endfunction

    task automatic check_vec(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (busy,pidx[8],rstc,conv,accu,rd,mp,to)", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clk_step(input bit st, input bit ab, input logic [7:0] cf, input bit pv);
        start        = st;
        abort        = ab;
        cfg_pass_num = cf;
        pixel_valid  = pv;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_pass  = 0;
        m_pix   = 0;
        m_clr   = 1'b0;
        m_acc   = 1'b0;
        m_rd    = 1'b0;
        m_mp    = 1'b0;
    endtask

    // One clock: drive, advance the model by the same edge, compare everything.
    task automatic model_step(input string name, input int cyc, input bit st, input bit ab,
                              input logic [7:0] cf, input bit pv);
        logic [14:0] exp;
        clk_step(st, ab, cf, pv);
        m_clr = 1'b0;
        m_acc = 1'b0;
        m_rd  = 1'b0;
        m_mp  = 1'b0;
        if (ab && m_state != M_IDLE) begin
            m_state = M_IDLE;
            m_clr   = 1'b1;
        end else begin
            case (m_state)
                M_IDLE: if (st && !ab) begin
                    m_p     = clamp_cfg(int'(cf));
                    m_pass  = 0;
                    m_pix   = 0;
                    m_state = M_PASS;
                end
                M_PASS: if (pv) begin
                    m_acc = (m_pix >= FILL);
                    m_rd  = m_acc && (m_pass != 0);
                    m_mp  = m_acc && (m_pass == m_p - 1);
                    m_pix++;
                    if (m_pix == NPIX) begin
                        m_pix   = 0;
                        m_state = M_GAP;
                    end
                end
                M_GAP: if (m_pass == m_p - 1) begin
                    m_state = M_DONE;
                end else begin
                    m_pass++;
                    m_state = M_PASS;
                end
                default: m_state = M_IDLE;
            endcase
        end
        exp = pk(m_state != M_IDLE, m_pass, !(m_state == M_GAP || m_clr), m_state == M_PASS,
                 m_acc, m_rd, m_mp, m_state == M_DONE);
        check_vec($sformatf("%s cycle %0d", name, cyc), act_vec, exp);
        cnt_acc += int'(valid_in_accu);
        cnt_rd  += int'(valid_in_rd_en);
        cnt_mp  += int'(valid_in_maxpool);
        cnt_clr += int'(!rst_n_conv);
        cnt_to  += int'(task_over);
        if (int'(pass_idx) > max_pidx) max_pidx = int'(pass_idx);
    endtask

    // Full task: start at cycle 0, feed pixels while the model is in PASS.
    task automatic run(input string name, input int cfg, input bit bub, input int ab_pass,
                       input int ab_pix, input int rs_cyc, input int e_acc, input int e_rd,
                       input int e_mp, input int e_clr, input int e_to, input int e_to_cyc,
                       input int e_fall, input int e_maxp);
        int cyc, to_cyc, fall;
        bit tog, pv, ab, st;
        logic [7:0] cf;
        cnt_acc = 0; cnt_rd = 0; cnt_mp = 0; cnt_clr = 0; cnt_to = 0; max_pidx = 0;
        to_cyc = -1; fall = -1; tog = 1'b1;
        model_step(name, 1, 1'b1, 1'b0, 8'(cfg), 1'b0);
        cyc = 1;
        while (m_state != M_IDLE && cyc < 600) begin
            pv = 1'b0;
            ab = 1'b0;
            if (m_state == M_PASS) begin
                pv  = bub ? tog : 1'b1;
                tog = !tog;
                ab  = (m_pass == ab_pass) && (m_pix == ab_pix);
            end
            st = (cyc == rs_cyc);
            cf = st ? 8'd8 : 8'(cfg);
            model_step(name, cyc + 1, st, ab, cf, pv);
            cyc++;
            if (task_over && to_cyc < 0) to_cyc = cyc;
            if (!busy && fall < 0) fall = cyc;
        end
        model_step(name, cyc + 1, 1'b0, 1'b0, 8'(cfg), 1'b0);
        cyc++;
        if (!busy && fall < 0) fall = cyc;
        check_int({name, " accu pulses"}, cnt_acc, e_acc);
        check_int({name, " rd_en pulses"}, cnt_rd, e_rd);
        check_int({name, " maxpool pulses"}, cnt_mp, e_mp);
        check_int({name, " rst_n_conv low cycles"}, cnt_clr, e_clr);
        check_int({name, " task_over pulses"}, cnt_to, e_to);
        check_int({name, " task_over cycle"}, to_cyc, e_to_cyc);
        check_int({name, " busy fall cycle"}, fall, e_fall);
        check_int({name, " max pass_idx"}, max_pidx, e_maxp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        model_reset();

        // Reset state while rst_n is held low
        repeat (3) @(posedge clk);
        #1;
        check_vec("reset state", act_vec, pk(0, 0, 1, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Protocol corners from IDLE; each row is one clock edge.
        vecs[0] = '{1'b1, 1'b1, 8'd1, 1'b1, pk(0, 0, 1, 0, 0, 0, 0, 0)}; // abort+start: stay IDLE
        vecs[1] = '{1'b0, 1'b0, 8'd0, 1'b1, pk(0, 0, 1, 0, 0, 0, 0, 0)}; // pixel ignored in IDLE
        vecs[2] = '{1'b1, 1'b0, 8'd2, 1'b1, pk(1, 0, 1, 1, 0, 0, 0, 0)}; // start accepted
        vecs[3] = '{1'b1, 1'b0, 8'd5, 1'b1, pk(1, 0, 1, 1, 0, 0, 0, 0)}; // start while busy ignored
        vecs[4] = '{1'b0, 1'b0, 8'd0, 1'b0, pk(1, 0, 1, 1, 0, 0, 0, 0)}; // bubble
        vecs[5] = '{1'b0, 1'b1, 8'd0, 1'b1, pk(0, 0, 0, 0, 0, 0, 0, 0)}; // abort: clear pulse
        vecs[6] = '{1'b0, 1'b0, 8'd0, 1'b0, pk(0, 0, 1, 0, 0, 0, 0, 0)}; // clear released
        vecs[7] = '{1'b0, 1'b1, 8'd0, 1'b0, pk(0, 0, 1, 0, 0, 0, 0, 0)}; // abort in IDLE: no pulse
        for (int i = 0; i < 8; i++) begin
            clk_step(vecs[i].st, vecs[i].ab, vecs[i].cfg, vecs[i].pv);
            check_vec($sformatf("vector %0d", i), act_vec, vecs[i].exp);
        end

        //   name            cfg bub abP abX rs  acc rd  mp clr to toc fall maxp
        run("single pass",   1,  0,  -1, -1, -1, 8,  0,  8, 1,  1, 18, 19,  0);
        run("three passes",  3,  0,  -1, -1, 5,  24, 16, 8, 3,  1, 52, 53,  2);
        run("bubbles",       1,  1,  -1, -1, -1, 8,  0,  8, 1,  1, 33, 34,  0);
`ifdef SEQ_STALL_CNT_EN
        check_int("bubbles stall_cnt", int'(stall_cnt), 15);
`endif
        run("cfg zero",      0,  0,  -1, -1, -1, 8,  0,  8, 1,  1, 18, 19,  0);
        run("cfg clamp",     20, 0,  -1, -1, -1, 64, 56, 8, 8,  1, 137, 138, 7);
        run("abort pass 1",  3,  0,  1,  4,  -1, 8,  0,  0, 2,  0, -1, 23,  1);
        run("after abort",   1,  0,  -1, -1, -1, 8,  0,  8, 1,  1, 18, 19,  0);

        // Asynchronous reset in the middle of a pass
        model_step("async pre", 1, 1'b1, 1'b0, 8'd2, 1'b0);
        for (int i = 0; i < 10; i++) model_step("async pre", i + 2, 1'b0, 1'b0, 8'd2, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check_vec("async reset immediate", act_vec, pk(0, 0, 1, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check_vec("async reset held", act_vec, pk(0, 0, 1, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        model_step("post reset idle", 1, 1'b0, 1'b0, 8'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
